// File: rtl/seq_pkg.sv
// Shared constants for the instruction sequencer: opcodes, ALU select codes,
// FSM states and instruction classes.
package seq_pkg;

    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_SUB   = 8'h02;
    localparam logic [7:0] OP_AND   = 8'h03;
    localparam logic [7:0] OP_OR    = 8'h04;
    localparam logic [7:0] OP_LOAD  = 8'h05;
    localparam logic [7:0] OP_STORE = 8'h06;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_NOP,
        CLS_HALT
    } op_class_t;

    // Only arithmetic ops update the carry flag; logic ops leave it alone.
    function automatic logic updates_carry(input logic [7:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB);
    endfunction

endpackage

// File: rtl/seq_decoder.sv
// Combinational opcode decoder: maps an opcode to its ALU select code and
// instruction class. Unknown opcodes decode as NOP.
module seq_decoder
    import seq_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic [3:0] o_alu_sel,
    output logic [2:0] o_op_class
);

    op_class_t w_class;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        o_alu_sel = ALU_ADD;
        w_class   = CLS_NOP;
        case (i_opcode)
            OP_ADD: begin
                o_alu_sel = ALU_ADD;
                w_class   = CLS_ALU;
            end
            OP_SUB: begin
                o_alu_sel = ALU_SUB;
                w_class   = CLS_ALU;
            end
            OP_AND: begin
                o_alu_sel = ALU_AND;
                w_class   = CLS_ALU;
            end
            OP_OR: begin
                o_alu_sel = ALU_OR;
                w_class   = CLS_ALU;
            end
            OP_LOAD:  w_class = CLS_LOAD;
            OP_STORE: w_class = CLS_STORE;
            OP_HALT:  w_class = CLS_HALT;
            default:  w_class = CLS_NOP;
        endcase
    end

    assign o_op_class = w_class;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction at a time, steps
// it through DECODE/EXEC/MEM/WB and drives an external ALU, register file and data memory.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,

    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,

    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,

    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata,

    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              carry_flag,
    output logic [CNT_W-1:0]  retired_count
);

    state_t              r_state;
    logic [31:0]         r_instr;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_carry;
    logic [CNT_W-1:0]    r_retired;

    logic [7:0]          w_opcode;
    logic [ADDR_W-1:0]   w_rd;
    logic [ADDR_W-1:0]   w_rs1;
    logic [ADDR_W-1:0]   w_rs2;
    logic [3:0]          w_alu_sel;
    logic [2:0]          w_op_class_raw;
    op_class_t           w_op_class;

    // Fields are taken from the latched copy, so the bus may change freely
    // once the instruction has been accepted.
    assign w_opcode   = r_instr[31:24];
    assign w_rd       = ADDR_W'(r_instr[23:16]);
    assign w_rs1      = ADDR_W'(r_instr[15:8]);
    assign w_rs2      = ADDR_W'(r_instr[7:0]);
    assign w_op_class = op_class_t'(w_op_class_raw);

    seq_decoder u_decoder (
        .i_opcode   (w_opcode),
        .o_alu_sel  (w_alu_sel),
        .o_op_class (w_op_class_raw)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from the same edge regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_instr   <= '0;
            r_wb_data <= '0;
            r_carry   <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (w_op_class)
                        CLS_ALU:   r_state <= ST_EXEC;
                        CLS_LOAD,
                        CLS_STORE: r_state <= ST_MEM;
                        CLS_HALT: begin
                            r_state   <= ST_HALT;
                            r_retired <= r_retired + CNT_W'(1);
                        end
                        default: begin
                            r_state   <= ST_WB;
                            r_retired <= r_retired + CNT_W'(1);
                        end
                    endcase
                end
                // The count steps on entry to WB so it is already visible in
                // the done cycle; an aborting reset before then never counts.
                ST_EXEC: begin
                    r_wb_data <= alu_result;
                    if (updates_carry(w_opcode)) begin
                        r_carry <= alu_carry;
                    end
                    r_state   <= ST_WB;
                    r_retired <= r_retired + CNT_W'(1);
                end
                ST_MEM: begin
                    if (w_op_class == CLS_LOAD) begin
                        r_wb_data <= dm_rdata;
                    end
                    r_state   <= ST_WB;
                    r_retired <= r_retired + CNT_W'(1);
                end
                ST_WB:   r_state <= ST_IDLE;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_sel   = '0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_we     = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_DECODE: begin
                rf_raddr1 = w_rs1;
                rf_raddr2 = w_rs2;
            end
            ST_EXEC: begin
                rf_raddr1 = w_rs1;
                rf_raddr2 = w_rs2;
                alu_sel   = w_alu_sel;
            end
            ST_MEM: begin
                dm_addr = w_rs2;
                if (w_op_class == CLS_STORE) begin
                    rf_raddr1 = w_rd;
                    dm_wdata  = rf_rdata1;
                    dm_we     = 1'b1;
                end
            end
            ST_WB: begin
                done = 1'b1;
                if (w_op_class == CLS_ALU || w_op_class == CLS_LOAD) begin
                    rf_we    = 1'b1;
                    rf_waddr = w_rd;
                    rf_wdata = r_wb_data;
                end
            end
            default: ;
        endcase
    end

    assign instr_ready   = (r_state == ST_IDLE) && !reset;
    assign busy          = (r_state != ST_IDLE);
    assign halted        = (r_state == ST_HALT);
    assign carry_flag    = r_carry;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: ALU, memory, NOP, HALT, reset-abort and
// retired-count wrap, with hand-computed expectations.
module tb_instr_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    // A narrow counter keeps the wrap test to a few hundred cycles.
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_we;
    logic [DATA_W-1:0] dm_rdata;
    logic              busy;
    logic              done;
    logic              halted;
    logic              carry_flag;
    logic [CNT_W-1:0]  retired_count;

    int n_vec = 0;
    int n_err = 0;

    instr_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .alu_sel       (alu_sel),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_we         (rf_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_we         (dm_we),
        .dm_rdata      (dm_rdata),
        .busy          (busy),
        .done          (done),
        .halted        (halted),
        .carry_flag    (carry_flag),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        alu_result  = '0;
        alu_carry   = 1'b0;
        rf_rdata1   = '0;
        dm_rdata    = '0;

        // Reset state
        step(2);
        check("rst_ready", instr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_count", retired_count, 0);
        check("rst_carry", carry_flag, 0);
        check("rst_halted", halted, 0);
        check("rst_we", {rf_we, dm_we, done}, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", instr_ready, 1);

        // ADD r3 = r1 + r2 (0xF0 + 0x20 = 0x110)
        instr       = {8'h01, 8'd3, 8'd1, 8'd2};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        alu_result  = 8'h10;
        alu_carry   = 1'b1;
        check("add_dec_busy", busy, 1);
        check("add_dec_ready", instr_ready, 0);
        check("add_dec_raddr", {rf_raddr1, rf_raddr2}, {8'd1, 8'd2});
        step();
        check("add_exec_sel", alu_sel, 4'b0000);
        check("add_exec_wb", {rf_we, done}, 0);
        step();
        check("add_wb_we", rf_we, 1);
        check("add_wb_waddr", rf_waddr, 3);
        check("add_wb_wdata", rf_wdata, 8'h10);
        check("add_wb_carry", carry_flag, 1);
        check("add_wb_done", done, 1);
        check("add_wb_count", retired_count, 1);
        check("add_wb_dmwe", dm_we, 0);
        step();
        check("add_idle", {done, rf_we, instr_ready}, 3'b001);

        // STORE r5 -> 0x40 with r5 = 0xAB
        instr       = {8'h06, 8'd5, 8'd0, 8'h40};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        rf_rdata1   = 8'hAB;
        step();
        check("st_mem_we", {dm_we, rf_we}, 2'b10);
        check("st_mem_addr", dm_addr, 8'h40);
        check("st_mem_wdata", dm_wdata, 8'hAB);
        check("st_mem_raddr1", rf_raddr1, 5);
        step();
        check("st_wb_we", {dm_we, rf_we}, 2'b00);
        check("st_wb_done", done, 1);
        check("st_wb_count", retired_count, 2);
        step();

        // LOAD r6 <- mem[0x40]
        instr       = {8'h05, 8'd6, 8'd0, 8'h40};
        instr_valid = 1'b1;
        rf_rdata1   = 8'h00;
        dm_rdata    = 8'hAB;
        step();
        instr_valid = 1'b0;
        step();
        check("ld_mem_addr", dm_addr, 8'h40);
        check("ld_mem_we", {dm_we, rf_we}, 2'b00);
        step();
        check("ld_wb", {rf_we, dm_we, done}, 3'b101);
        check("ld_wb_waddr", rf_waddr, 6);
        check("ld_wb_wdata", rf_wdata, 8'hAB);
        check("ld_wb_count", retired_count, 3);
        step();

        // AND r7 = r1 & r2 leaves carry untouched
        instr       = {8'h03, 8'd7, 8'd1, 8'd2};
        instr_valid = 1'b1;
        alu_result  = 8'h55;
        alu_carry   = 1'b0;
        step();
        instr_valid = 1'b0;
        step();
        check("and_exec_sel", alu_sel, 4'b1000);
        step();
        check("and_wb_wdata", rf_wdata, 8'h55);
        check("and_wb_carry", carry_flag, 1);
        check("and_wb_count", retired_count, 4);
        step();

        // SUB then NOP back-to-back, valid held high, from a fresh reset
        reset = 1'b1;
        step();
        reset       = 1'b0;
        instr       = {8'h02, 8'd4, 8'd1, 8'd2};
        instr_valid = 1'b1;
        alu_result  = 8'hF0;
        alu_carry   = 1'b1;
        check("sub_carry_pre", carry_flag, 0);
        step();
        instr = {8'h00, 8'd9, 8'd9, 8'd9};
        check("sub_c1_ready", instr_ready, 0);
        step();
        check("sub_c2_ready", instr_ready, 0);
        check("sub_exec_sel", alu_sel, 4'b0001);
        step();
        check("sub_c3_ready", instr_ready, 0);
        check("sub_wb_waddr", rf_waddr, 4);
        check("sub_wb", {rf_we, done, carry_flag}, 3'b111);
        check("sub_wb_count", retired_count, 1);
        step();
        check("nop_accept_ready", instr_ready, 1);
        step();
        instr_valid = 1'b0;
        check("nop_c1", {done, rf_we, dm_we}, 0);
        step();
        check("nop_wb", {done, rf_we, dm_we}, 3'b100);
        check("nop_wb_count", retired_count, 2);
        step();

        // Reset while an ADD is in EXEC aborts it
        instr       = {8'h01, 8'd3, 8'd1, 8'd2};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        check("abort_in_exec", alu_sel, 4'b0000);
        reset = 1'b1;
        step();
        check("abort_rst", {rf_we, done, instr_ready}, 0);
        check("abort_count", retired_count, 0);
        reset = 1'b0;
        #1;
        check("abort_ready", instr_ready, 1);
        step();
        check("abort_after1", {rf_we, done, dm_we}, 0);
        step();
        check("abort_after2", {rf_we, done}, 0);
        check("abort_count2", retired_count, 0);

        // HALT, then hammer instr_valid for 10 cycles
        instr       = {8'hFF, 8'd0, 8'd0, 8'd0};
        instr_valid = 1'b1;
        step();
        instr = {8'h01, 8'd3, 8'd1, 8'd2};
        step();
        check("halt_entry", {halted, done}, 2'b10);
        check("halt_count", retired_count, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_hold", {halted, instr_ready, rf_we, dm_we, done}, 5'b10000);
        end
        check("halt_count_hold", retired_count, 1);
        instr_valid = 1'b0;
        reset = 1'b1;
        step();
        check("halt_cleared", {halted, busy}, 0);
        reset = 1'b0;

        // Retired count wrap: 63 NOPs reach all-ones, one more returns to 0
        instr       = {8'h07, 8'd1, 8'd1, 8'd1};
        instr_valid = 1'b1;
        for (int k = 0; k < 63; k++) begin
            step(3);
        end
        check("wrap_allones", retired_count, 6'h3F);
        step(2);
        check("wrap_zero", retired_count, 0);
        check("wrap_done", {done, rf_we}, 2'b10);
        instr_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
